// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - pipelined IF stage with an in-order {pc,inst} prefetch queue
// Optional feature macro: FETCH_BYPASS_EN (a response reaches ID in its arrival cycle when the queue is empty)
module fetch_prefetch_queue #(
  parameter logic [31:0] START_ADDR = 32'h00000034,
  parameter int          QDEPTH     = 4,
  parameter int          MAX_OUTST  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      imem_req,
  output logic [31:0]               imem_addr,
  input  logic                      imem_gnt,
  input  logic                      imem_rvalid,
  input  logic [31:0]               imem_rdata,
  input  logic                      jbr_taken,
  input  logic [31:0]               jbr_target,
  input  logic                      exc_valid,
  input  logic [31:0]               exc_pc,
  output logic                      IF_ID_valid,
  input  logic                      id_ready,
  output logic [63:0]               IF_ID_bus,
  output logic [31:0]               IF_pc,
  output logic [31:0]               IF_inst,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int QPW = $clog2(QDEPTH);
  localparam int CW  = QPW + 1;
  localparam int OPW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int OCW = $clog2(MAX_OUTST + 1);

  typedef enum logic {BOOT, RUN} state_t;

  state_t           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [QPW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [QPW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [OCW-1:0]   outst_q, outst_d;
  logic [OCW-1:0]   drop_q, drop_d;
  logic [63:0]      q_mem_q [QDEPTH];
  logic [63:0]      q_mem_d [QDEPTH];
  // pcs of issued-but-unanswered requests, oldest at pcf_rd
  logic [31:0]      pcf_mem_q [MAX_OUTST];
  logic [31:0]      pcf_mem_d [MAX_OUTST];
  logic [OPW-1:0]   pcf_rd_q, pcf_rd_d;
  logic [OPW-1:0]   pcf_wr_q, pcf_wr_d;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic        q_empty;
  logic [31:0] resp_pc;
  logic        resp_keep;
  logic        bypass;
  logic        pop_q;
  logic        push;
  logic        issue;

  // Datapath decisions for this cycle: issue, response handling, ID handshake
  always_comb begin
    redirect    = exc_valid | jbr_taken;
    redirect_pc = exc_valid ? exc_pc : jbr_target;
    q_empty     = (count_q == '0);
    resp_pc     = pcf_mem_q[pcf_rd_q];
    // responses are only kept when nothing stale is still due and no flush is happening
    resp_keep   = imem_rvalid && (drop_q == '0) && !redirect;
`ifdef FETCH_BYPASS_EN
    bypass      = resp_keep && q_empty;
`else
    bypass      = 1'b0;
`endif
    IF_ID_valid = !q_empty || bypass;
    if (!q_empty) begin
      IF_ID_bus = q_mem_q[rd_ptr_q];
    end else if (bypass) begin
      IF_ID_bus = {resp_pc, imem_rdata};
    end else begin
      IF_ID_bus = '0;
    end
    IF_pc   = IF_ID_bus[63:32];
    IF_inst = IF_ID_bus[31:0];
    q_count = count_q;
    pop_q   = IF_ID_valid && id_ready && !q_empty;
    push    = resp_keep && !(bypass && id_ready);
    // credit: every in-flight request already owns a queue slot
    imem_req  = (state_q == RUN) && ((32'(count_q) + 32'(outst_q)) < 32'(QDEPTH)) &&
                (outst_q < OCW'(MAX_OUTST)) && !redirect;
    imem_addr = fetch_pc_q;
    issue     = imem_req && imem_gnt;
  end

  // Next-state: fetch pc, in-flight/drop counters, pc FIFO and queue pointers
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    pcf_mem_d  = pcf_mem_q;
    pcf_rd_d   = pcf_rd_q;
    pcf_wr_d   = pcf_wr_q;
    q_mem_d    = q_mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    case (state_q)
      BOOT:    state_d = RUN;
      default: state_d = RUN;
    endcase

    if (redirect) begin
      fetch_pc_d = redirect_pc;
    end else if (issue) begin
      fetch_pc_d = {fetch_pc_q[31:2] + 30'd1, fetch_pc_q[1:0]};
    end

    if (issue) begin
      pcf_mem_d[pcf_wr_q] = fetch_pc_q;
      pcf_wr_d = (pcf_wr_q == OPW'(MAX_OUTST - 1)) ? '0 : pcf_wr_q + 1'b1;
    end
    if (imem_rvalid) begin
      pcf_rd_d = (pcf_rd_q == OPW'(MAX_OUTST - 1)) ? '0 : pcf_rd_q + 1'b1;
    end

    case ({issue, imem_rvalid})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase

    // a redirect never issues, so every request still in flight after it is stale
    if (redirect) begin
      drop_d = outst_d;
    end else if (imem_rvalid && (drop_q != '0)) begin
      drop_d = drop_q - 1'b1;
    end

    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        q_mem_d[wr_ptr_q] = {resp_pc, imem_rdata};
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_q) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop_q})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BOOT;
      fetch_pc_q <= START_ADDR;
      outst_q    <= '0;
      drop_q     <= '0;
      pcf_rd_q   <= '0;
      pcf_wr_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < MAX_OUTST; i++) pcf_mem_q[i] <= '0;
      for (int i = 0; i < QDEPTH; i++) q_mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      pcf_rd_q   <= pcf_rd_d;
      pcf_wr_q   <= pcf_wr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      pcf_mem_q  <= pcf_mem_d;
      q_mem_q    <= q_mem_d;
    end
  end

  // A response landing on a full queue means the issue credit check is broken
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(push && !pop_q && (count_q == CW'(QDEPTH))));
    end
  end

endmodule
